serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  requester presents operands.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 op_a  input  WIDTH  operand A, sampled on accept.
REQ-007 op_b  input  WIDTH  operand B, sampled on accept.
REQ-008 cin  input  1  carry-in, sampled on accept.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  result, LSB first assembled.
REQ-012 cout  output  1  final carry-out.
REQ-013 busy  output  1  high in RUN state only.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding from shared package.
REQ-015 IDLE: req_ready=1; req_valid=1 -> latch op_a, op_b, cin into shift/carry registers, clear bit counter, go RUN.
REQ-016 RUN: each cycle one full-adder evaluation on LSBs of A, B shift registers plus carry flop; sum bit shifted into result MSB, A/B shifted right, carry flop updated.
REQ-017 Bit counter counts 0..WIDTH-1; at count WIDTH-1 the last bit completes and FSM goes DONE next edge.
REQ-018 Latency: accept edge at cycle 0 -> rsp_valid high from cycle WIDTH+1 (exactly WIDTH RUN cycles).
REQ-019 DONE: rsp_valid=1, sum/cout stable; rsp_ready=1 -> go IDLE next edge; result held until then (no drop, no overwrite).
REQ-020 req_ready=0 in RUN and DONE; requests then are ignored, not queued.
REQ-021 rsp_ready outside DONE has no effect.
REQ-022 Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1); no saturation.
REQ-023 sum and cout change only on the RUN->DONE edge as seen externally (internal shift register may be exposed only in DONE; sum output registered from final value).
REQ-024 Back-to-back: DONE with rsp_ready=1 -> IDLE one cycle; next accept no earlier than that IDLE cycle (throughput one result per WIDTH+2 cycles).

Reset
REQ-025 rst asserted: state=IDLE, req_ready=1, rsp_valid=0, busy=0, sum=0, cout=0, counter=0, carry flop=0, immediately, without clk.
REQ-026 rst mid-RUN or mid-DONE aborts the operation; no rsp_valid is produced for it.
REQ-027 Deassertion takes effect on next rising clk edge; first accept possible that edge.

Structure
REQ-028 Package serial_add_pkg holds state enum type, default WIDTH constant, counter-width function (clog2).
REQ-029 One sub-module full_add_cell: combinational 1-bit full adder (a, b, ci -> s, co), instantiated once in the datapath.
REQ-030 Controller FSM, counter, shift registers stay in serial_add_ctrl.

Verification
REQ-031 WIDTH=8, op_a=0x05, op_b=0x03, cin=0 -> sum=0x08, cout=0, rsp_valid first high at cycle 9 after accept.
REQ-032 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple through all bits).
REQ-033 op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 rsp_ready held low 5 cycles in DONE -> rsp_valid, sum, cout stable all 5 cycles; req_valid pulses ignored; accept only after IDLE.
REQ-035 rst pulsed at RUN count 3 -> all outputs at reset values asynchronously; no rsp_valid follows; subsequent 0x10+0x20 gives 0x30.
REQ-036 Random 1000 transactions with random req_valid/rsp_ready gaps -> every result matches op_a+op_b+cin, none lost or duplicated.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response handshake bundle between a requester and serial_add_ctrl.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output req_valid, op_a, op_b, cin, rsp_ready,
    input  req_ready, rsp_valid, sum, cout, busy
  );

  modport slave (
    input  req_valid, op_a, op_b, cin, rsp_ready,
    output req_ready, rsp_valid, sum, cout, busy
  );
endinterface

// File: rtl/full_add_cell.sv
// Combinational 1-bit full adder used as the serial datapath core.
module full_add_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per cycle, LSB first, result held in DONE
// until the consumer takes it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout;
  logic [CntW-1:0]  r_cnt;
  logic             w_accept, w_step, w_last, w_s, w_co;

  full_add_cell u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    w_last        = (r_cnt == LastCnt);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        bus.busy = 1'b1;
        w_step   = 1'b1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // The A register doubles as the result shifter: sum bits enter at the MSB as A drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.op_b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= {w_s, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {w_s, r_a[WIDTH-1:1]};
        r_cout <= w_co;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against a plain-arithmetic reference.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned NRand = 1000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (bus.rsp_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cin = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100",
               {bus.req_ready, bus.rsp_valid, bus.busy});
    end
    checks++;
    if ({bus.cout, bus.sum} !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", {bus.cout, bus.sum});
    end
    step();
    rst = 1'b0;
    // Accept must be possible on the first edge after deassertion.
    bus.op_a = 8'h01;
    bus.op_b = 8'h02;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept: busy got %b expected 1", bus.busy);
    end
    wait_rsp(1, cyc);
    checks++;
    if (bus.rsp_valid !== 1'b1 || {bus.cout, bus.sum} !== model(8'h01, 8'h02, 1'b0)) begin
      errors++;
      $display("FAIL reset_first_result: got vld=%b %h expected vld=1 %h", bus.rsp_valid,
               {bus.cout, bus.sum}, model(8'h01, 8'h02, 1'b0));
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    logic         vc[6];
    logic [W:0]   exp;
    int           cyc;
    va[0] = 8'h05; vb[0] = 8'h03; vc[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1;
    for (int i = 3; i < 6; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      exp = model(va[i], vb[i], vc[i]);
      bus.op_a = va[i];
      bus.op_b = vb[i];
      bus.cin = vc[i];
      bus.req_valid = 1'b1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_ready: got %b expected 1", i, bus.req_ready);
      end
      step();
      bus.req_valid = 1'b0;
      bus.op_a = ~va[i];
      checks++;
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_run: got busy=%b rdy=%b expected busy=1 rdy=0", i, bus.busy,
                 bus.req_ready);
      end
      wait_rsp(1, cyc);
      checks++;
      if (cyc != int'(W) + 1) begin
        errors++;
        $display("FAIL dir%0d_latency: got cycle %0d expected %0d", i, cyc, W + 1);
      end
      checks++;
      if ({bus.cout, bus.sum} !== exp) begin
        errors++;
        $display("FAIL dir%0d_sum: got %h expected %h", i, {bus.cout, bus.sum}, exp);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_release: got vld=%b rdy=%b expected vld=0 rdy=1", i,
                 bus.rsp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [W:0] exp, exp2;
    int         cyc;
    bit         moved;
    exp = model(8'h3C, 8'h42, 1'b1);
    bus.op_a = 8'h3C;
    bus.op_b = 8'h42;
    bus.cin = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    wait_rsp(1, cyc);
    for (int i = 0; i < 6; i++) begin
      bus.rsp_ready = 1'b0;
      bus.req_valid = (i < 5);
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      checks++;
      if (bus.rsp_valid !== 1'b1 || {bus.cout, bus.sum} !== exp || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got vld=%b rdy=%b %h expected vld=1 rdy=0 %h", i,
                 bus.rsp_valid, bus.req_ready, {bus.cout, bus.sum}, exp);
      end
      if (i < 5) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
        {bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL hold_release: got vld=%b busy=%b rdy=%b %h expected 0 0 1 %h",
               bus.rsp_valid, bus.busy, bus.req_ready, {bus.cout, bus.sum}, exp);
    end
    // Outputs must keep the old result through the whole next computation.
    exp2 = model(8'h01, 8'h01, 1'b0);
    bus.op_a = 8'h01;
    bus.op_b = 8'h01;
    bus.cin = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    moved = 1'b0;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 100) begin
      if ({bus.cout, bus.sum} !== exp) moved = 1'b1;
      step();
      cyc++;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL hold_sum_stable_in_run: got changing output expected %h", exp);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || {bus.cout, bus.sum} !== exp2) begin
      errors++;
      $display("FAIL hold_next_result: got vld=%b %h expected vld=1 %h", bus.rsp_valid,
               {bus.cout, bus.sum}, exp2);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    bus.op_a = 8'hA5;
    bus.op_b = 8'h5A;
    bus.cin = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 3'b100 || {bus.cout, bus.sum} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy/vld/busy=%b %h expected 100 0",
               {bus.req_ready, bus.rsp_valid, bus.busy}, {bus.cout, bus.sum});
    end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * int'(W); i++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_no_rsp: got rsp_valid after abort expected none");
    end
    bus.op_a = 8'h10;
    bus.op_b = 8'h20;
    bus.cin = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    wait_rsp(1, cyc);
    checks++;
    if (bus.rsp_valid !== 1'b1 || {bus.cout, bus.sum} !== 9'h030) begin
      errors++;
      $display("FAIL midrun_after: got vld=%b %h expected vld=1 030", bus.rsp_valid,
               {bus.cout, bus.sum});
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W:0] q[$];
    logic [W:0] exp;
    int         acc = 0;
    int         got = 0;
    int         cyc = 0;
    while (got < int'(NRand) && cyc < 60000) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected_rsp: got %h expected no response",
                   {bus.cout, bus.sum});
        end else begin
          exp = q.pop_front();
          if ({bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL rand_result%0d: got %h expected %h", got, {bus.cout, bus.sum}, exp);
          end
        end
        got++;
      end
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.cin = 1'($urandom);
      bus.req_valid = (acc < int'(NRand)) && ($urandom_range(0, 2) != 0);
      if (bus.req_valid && bus.req_ready === 1'b1) begin
        q.push_back(model(bus.op_a, bus.op_b, bus.cin));
        acc++;
      end
      step();
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (got != int'(NRand) || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d responses, %0d pending expected %0d, 0", got,
               q.size(), NRand);
    end
    step();
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_trailing_rsp: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
